// File: rtl/bus_mem_target_if.sv
// -----------------------------------------------------------------------------
// bus_mem_target_if
// Main bus command / read / write / error bundle between the fetch/memory
// stages (master) and an SRAM-backed responder (slave).
//   cvalid/cready/cmd/addr : one command, cmd 1 = read line, 0 = write line
//   rvalid/rready/rlast/rdata : read beats, 4 per line
//   wvalid/wready/wlast/wdata/wmask : write beats, up to 4 per line
//   error/eack : sticky access error and its acknowledge
// -----------------------------------------------------------------------------
interface bus_mem_target_if;
    logic        cvalid;
    logic        cready;
    logic        cmd;
    logic [26:0] addr;
    logic        rvalid;
    logic        rready;
    logic        rlast;
    logic [31:0] rdata;
    logic        wvalid;
    logic        wready;
    logic        wlast;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic        error;
    logic        eack;

    modport master (
        output cvalid, cmd, addr, rready, wvalid, wlast, wdata, wmask, eack,
        input  cready, rvalid, rlast, rdata, wready, error
    );

    modport slave (
        input  cvalid, cmd, addr, rready, wvalid, wlast, wdata, wmask, eack,
        output cready, rvalid, rlast, rdata, wready, error
    );
endinterface

// File: rtl/bus_mem_target.sv
// -----------------------------------------------------------------------------
// bus_mem_target
// Responder end of the main bus. Backs an on-chip synchronous SRAM of
// 2**DEPTH_LOG2 32-bit words mapped at word address BASE. Takes one command
// at a time: a read returns a 4-beat line burst and a write takes up to 4
// byte-masked beats, both wrapping inside the line from the requested word.
// Out-of-range commands raise error until acknowledged.
// Ports:
//   clk_core : core clock
//   reset_n  : asynchronous active-low reset
//   bus      : bus_mem_target_if.slave (command, read, write, error channels)
// -----------------------------------------------------------------------------
module bus_mem_target #(
    parameter int          DEPTH_LOG2 = 12,
    parameter logic [26:0] BASE       = 27'd0
) (
    input  logic           clk_core,
    input  logic           reset_n,
    bus_mem_target_if.slave bus
);

    localparam int          LINE_W      = DEPTH_LOG2 - 2;
    localparam logic [26:0] DEPTH_WORDS = 27'd1 << DEPTH_LOG2;
    localparam int          DEPTH       = int'(DEPTH_WORDS);

    typedef enum logic [3:0] {
        IDLE = 4'b0001,
        RD   = 4'b0010,
        WR   = 4'b0100,
        ERR  = 4'b1000
    } state_t;

    state_t              state_r;
    state_t              state_nx_s;
    logic [1:0]          beat_r;
    logic [1:0]          beat_nx_s;
    logic [LINE_W-1:0]   line_r;
    logic [1:0]          start_r;

    logic                cready_r;
    logic                rvalid_r;
    logic                rlast_r;
    logic [31:0]         rdata_r;
    logic                wready_r;
    logic                error_r;

    logic [31:0]         mem_r [DEPTH];

    logic [26:0]           offs_s;
    logic                  in_range_s;
    logic                  accept_s;
    logic                  rd_xfer_s;
    logic                  wr_xfer_s;
    logic [1:0]            cur_off_s;
    logic [1:0]            nxt_off_s;
    logic                  load_rd_s;
    logic [DEPTH_LOG2-1:0] rd_idx_s;
    logic [DEPTH_LOG2-1:0] wr_idx_s;

    // Offset from BASE in 27-bit unsigned arithmetic: addresses below BASE
    // wrap to huge offsets and therefore fall out of range as well.
    assign offs_s     = bus.addr - BASE;
    assign in_range_s = (offs_s < DEPTH_WORDS);
    assign accept_s   = bus.cvalid & cready_r;
    assign rd_xfer_s  = (state_r == RD) & rvalid_r & bus.rready;
    assign wr_xfer_s  = (state_r == WR) & bus.wvalid & wready_r;

    // 2-bit word offsets wrap 3 -> 0 inside the line by construction.
    assign cur_off_s  = start_r + beat_r;
    assign nxt_off_s  = start_r + beat_r + 2'd1;
    assign wr_idx_s   = {line_r, cur_off_s};

    assign bus.cready = cready_r;
    assign bus.rvalid = rvalid_r;
    assign bus.rlast  = rlast_r;
    assign bus.rdata  = rdata_r;
    assign bus.wready = wready_r;
    assign bus.error  = error_r;

    // Next-state, beat counter and SRAM read-address selection.
    always_comb begin
        state_nx_s = state_r;
        beat_nx_s  = beat_r;
        load_rd_s  = 1'b0;
        rd_idx_s   = {line_r, nxt_off_s};
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    beat_nx_s = 2'd0;
                    if (!in_range_s) begin
                        state_nx_s = ERR;
                    end else if (bus.cmd) begin
                        state_nx_s = RD;
                        load_rd_s  = 1'b1;
                        rd_idx_s   = {offs_s[DEPTH_LOG2-1:2], bus.addr[1:0]};
                    end else begin
                        state_nx_s = WR;
                    end
                end else begin
                    state_nx_s = IDLE;
                end
            end
            RD: begin
                if (rd_xfer_s) begin
                    if (beat_r == 2'd3) begin
                        state_nx_s = IDLE;
                        beat_nx_s  = 2'd0;
                    end else begin
                        // Fetch the following beat so it is valid next cycle.
                        beat_nx_s = beat_r + 2'd1;
                        load_rd_s = 1'b1;
                    end
                end else begin
                    state_nx_s = RD;
                end
            end
            WR: begin
                if (wr_xfer_s) begin
                    if (bus.wlast || (beat_r == 2'd3)) begin
                        state_nx_s = IDLE;
                        beat_nx_s  = 2'd0;
                    end else begin
                        beat_nx_s = beat_r + 2'd1;
                    end
                end else begin
                    state_nx_s = WR;
                end
            end
            ERR: begin
                if (bus.eack) begin
                    state_nx_s = IDLE;
                end else begin
                    state_nx_s = ERR;
                end
            end
            default: begin
                state_nx_s = IDLE;
                beat_nx_s  = 2'd0;
            end
        endcase
    end

    // State, command context and registered bus outputs.
    always_ff @(posedge clk_core or negedge reset_n) begin
        if (!reset_n) begin
            state_r  <= IDLE;
            beat_r   <= 2'd0;
            line_r   <= '0;
            start_r  <= 2'd0;
            cready_r <= 1'b1;
            rvalid_r <= 1'b0;
            rlast_r  <= 1'b0;
            rdata_r  <= 32'd0;
            wready_r <= 1'b0;
            error_r  <= 1'b0;
        end else begin
            state_r  <= state_nx_s;
            beat_r   <= beat_nx_s;
            if (accept_s) begin
                line_r  <= offs_s[DEPTH_LOG2-1:2];
                start_r <= bus.addr[1:0];
            end
            cready_r <= (state_nx_s == IDLE);
            rvalid_r <= (state_nx_s == RD);
            rlast_r  <= (state_nx_s == RD) && (beat_nx_s == 2'd3);
            wready_r <= (state_nx_s == WR);
            error_r  <= (state_nx_s == ERR);
            // rdata only moves on accept or transfer, so it holds under stall.
            if (load_rd_s) begin
                rdata_r <= mem_r[rd_idx_s];
            end
        end
    end

    // SRAM byte-masked write port; contents survive reset.
    always_ff @(posedge clk_core) begin
        if (wr_xfer_s) begin
            if (bus.wmask[0]) mem_r[wr_idx_s][7:0]   <= bus.wdata[7:0];
            if (bus.wmask[1]) mem_r[wr_idx_s][15:8]  <= bus.wdata[15:8];
            if (bus.wmask[2]) mem_r[wr_idx_s][23:16] <= bus.wdata[23:16];
            if (bus.wmask[3]) mem_r[wr_idx_s][31:24] <= bus.wdata[31:24];
        end
    end

endmodule

// File: tb/tb_bus_mem_target.sv
// -----------------------------------------------------------------------------
// tb_bus_mem_target
// Self-checking bench for bus_mem_target. A word-array reference model holds
// the expected SRAM contents; reads are checked beat by beat against it.
// -----------------------------------------------------------------------------
module tb_bus_mem_target;

    localparam int          DL     = 12;
    localparam int          NWORDS = 4096;
    localparam logic [26:0] BASE_W = 27'h0010000;

    logic clk_core = 1'b0;
    logic reset_n  = 1'b1;

    bus_mem_target_if bus ();

    bus_mem_target #(
        .DEPTH_LOG2 (DL),
        .BASE       (BASE_W)
    ) dut (
        .clk_core (clk_core),
        .reset_n  (reset_n),
        .bus      (bus)
    );

    always #5 clk_core = ~clk_core;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] ref_mem [NWORDS];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_core);
        #1;
    endtask

    function automatic logic [26:0] word_addr(input int line, input int off);
        return BASE_W + 27'(line * 4 + off);
    endfunction

    task automatic idle_inputs();
        bus.cvalid = 1'b0; bus.cmd = 1'b0; bus.addr = 27'd0;
        bus.rready = 1'b0; bus.wvalid = 1'b0; bus.wlast = 1'b0;
        bus.wdata = 32'd0; bus.wmask = 4'd0; bus.eack = 1'b0;
    endtask

    task automatic model_write(input int idx, input logic [31:0] d, input logic [3:0] m);
        for (int b = 0; b < 4; b++) begin
            if (m[b]) ref_mem[idx][8*b +: 8] = d[8*b +: 8];
        end
    endtask

    // Write burst; a burst of fewer than 4 beats must use wlast.
    task automatic do_write(input int line, input int start, input int nbeats,
                            input bit use_wlast, input bit noise, input bit extra_beat,
                            input logic [31:0] dv [4], input logic [3:0] mv [4]);
        bus.cvalid = 1'b1; bus.cmd = 1'b0; bus.addr = word_addr(line, start);
        tick();
        bus.cvalid = noise;
        check_eq("wr_cready_busy", 32'(bus.cready), 32'd0);
        for (int k = 0; k < nbeats; k++) begin
            while (noise && ($urandom_range(0, 3) == 0)) begin
                bus.wvalid = 1'b0;
                bus.cmd = 1'($urandom); bus.addr = 27'($urandom);
                check_eq("wr_wready", 32'(bus.wready), 32'd1);
                check_eq("wr_cready_busy", 32'(bus.cready), 32'd0);
                tick();
            end
            bus.wvalid = 1'b1; bus.wdata = dv[k]; bus.wmask = mv[k];
            bus.wlast  = use_wlast && (k == nbeats - 1);
            check_eq("wr_wready", 32'(bus.wready), 32'd1);
            tick();
            model_write(line * 4 + ((start + k) % 4), dv[k], mv[k]);
        end
        bus.wvalid = 1'b0; bus.wlast = 1'b0; bus.cvalid = 1'b0;
        check_eq("wr_done_cready", 32'(bus.cready), 32'd1);
        check_eq("wr_done_wready", 32'(bus.wready), 32'd0);
        if (extra_beat) begin
            // A stray beat after the burst has ended must not reach the SRAM.
            bus.wvalid = 1'b1; bus.wdata = 32'hDEAD_BEEF; bus.wmask = 4'hF; bus.wlast = 1'b1;
            tick();
            bus.wvalid = 1'b0; bus.wlast = 1'b0;
            check_eq("wr_extra_idle", 32'(bus.cready), 32'd1);
        end
    endtask

    // Read burst; abort_after >= 0 pulses reset after that many transfers.
    task automatic do_read(input int line, input int start, input int stall_beat,
                           input bit rand_rdy, input bit noise, input int abort_after);
        int  k;
        int  cyc;
        int  stall;
        bit  rdy;
        k = 0; cyc = 0; stall = 0;
        bus.cvalid = 1'b1; bus.cmd = 1'b1; bus.addr = word_addr(line, start);
        tick();
        bus.cvalid = noise;
        while (k < 4 && cyc < 64) begin
            check_eq("rd_rvalid", 32'(bus.rvalid), 32'd1);
            check_eq("rd_rdata", bus.rdata, ref_mem[line * 4 + ((start + k) % 4)]);
            check_eq("rd_rlast", 32'(bus.rlast), 32'(k == 3));
            check_eq("rd_cready_busy", 32'(bus.cready), 32'd0);
            if (k == stall_beat && stall < 3) begin
                rdy = 1'b0;
                stall++;
            end else if (rand_rdy) begin
                rdy = ($urandom_range(0, 3) != 0);
            end else begin
                rdy = 1'b1;
            end
            bus.rready = rdy;
            if (noise) begin
                bus.cmd = 1'($urandom); bus.addr = 27'($urandom);
            end
            tick();
            cyc++;
            if (rdy) k++;
            if (abort_after >= 0 && k == abort_after) begin
                reset_n = 1'b0;
                #1;
                check_eq("rst_rvalid", 32'(bus.rvalid), 32'd0);
                check_eq("rst_cready", 32'(bus.cready), 32'd1);
                check_eq("rst_rlast", 32'(bus.rlast), 32'd0);
                check_eq("rst_rdata", bus.rdata, 32'd0);
                bus.rready = 1'b0; bus.cvalid = 1'b0;
                #2;
                reset_n = 1'b1;
                return;
            end
        end
        bus.rready = 1'b0; bus.cvalid = 1'b0;
        check_eq("rd_beats", 32'(k), 32'd4);
        check_eq("rd_done_rvalid", 32'(bus.rvalid), 32'd0);
        check_eq("rd_done_cready", 32'(bus.cready), 32'd1);
    endtask

    // Out-of-range command: error held until eack, no read beats, no writes.
    task automatic do_error(input logic [26:0] addr, input bit cmd, input int wait_cyc);
        bus.cvalid = 1'b1; bus.cmd = cmd; bus.addr = addr;
        tick();
        bus.cvalid = 1'b0;
        for (int i = 0; i < wait_cyc; i++) begin
            bus.wvalid = 1'b1; bus.wdata = $urandom; bus.wmask = 4'hF; bus.rready = 1'b1;
            check_eq("err_error", 32'(bus.error), 32'd1);
            check_eq("err_rvalid", 32'(bus.rvalid), 32'd0);
            check_eq("err_cready", 32'(bus.cready), 32'd0);
            check_eq("err_wready", 32'(bus.wready), 32'd0);
            tick();
        end
        bus.wvalid = 1'b0; bus.rready = 1'b0;
        check_eq("err_error", 32'(bus.error), 32'd1);
        bus.eack = 1'b1;
        tick();
        bus.eack = 1'b0;
        check_eq("err_cleared", 32'(bus.error), 32'd0);
        check_eq("err_cready", 32'(bus.cready), 32'd1);
    endtask

    initial begin
        logic [31:0] dv [4];
        logic [3:0]  mv [4];
        int          line;
        int          nb;
        bit          wl;
        idle_inputs();

        // Reset values.
        #3 reset_n = 1'b0;
        #4;
        check_eq("reset_cready", 32'(bus.cready), 32'd1);
        check_eq("reset_rvalid", 32'(bus.rvalid), 32'd0);
        check_eq("reset_rlast", 32'(bus.rlast), 32'd0);
        check_eq("reset_rdata", bus.rdata, 32'd0);
        check_eq("reset_wready", 32'(bus.wready), 32'd0);
        check_eq("reset_error", 32'(bus.error), 32'd0);
        #10 reset_n = 1'b1;
        tick();

        // eack without a pending error does nothing.
        bus.eack = 1'b1;
        tick();
        bus.eack = 1'b0;
        check_eq("eack_idle_error", 32'(bus.error), 32'd0);
        check_eq("eack_idle_cready", 32'(bus.cready), 32'd1);

        // Initialise the lines the bench uses: 0..15 plus the top line 1023.
        for (int l = 0; l < 17; l++) begin
            for (int i = 0; i < 4; i++) begin
                dv[i] = $urandom; mv[i] = 4'hF;
            end
            do_write((l == 16) ? 1023 : l, 0, 4, 1'b1, 1'b0, 1'b0, dv, mv);
        end

        // Read wrap: words 0x10..0x13 = A,B,C,D, read from offset 2.
        dv[0] = 32'hAAAA_0000; dv[1] = 32'hBBBB_1111; dv[2] = 32'hCCCC_2222; dv[3] = 32'hDDDD_3333;
        for (int i = 0; i < 4; i++) mv[i] = 4'hF;
        do_write(4, 0, 4, 1'b1, 1'b0, 1'b0, dv, mv);
        do_read(4, 2, -1, 1'b0, 1'b0, -1);

        // Backpressure on beat 1 for three cycles.
        do_read(4, 2, 1, 1'b0, 1'b0, -1);

        // Masked write from offset 3, then back-to-back read of the line.
        dv[0] = 32'hAABB_CCDD; mv[0] = 4'b1111;
        dv[1] = 32'h1122_3344; mv[1] = 4'b0101;
        do_write(5, 3, 2, 1'b1, 1'b0, 1'b0, dv, mv);
        do_read(5, 0, -1, 1'b0, 1'b0, -1);

        // Range errors: just past the top (aliases line 4) and just below BASE.
        do_error(BASE_W + 27'd4096 + 27'd16, 1'b1, 5);
        do_error(BASE_W - 27'd4, 1'b0, 3);
        do_read(4, 0, -1, 1'b0, 1'b0, -1);
        do_read(1023, 3, -1, 1'b0, 1'b0, -1);

        // Reset mid-read after two transfers, then a clean re-read.
        do_read(6, 1, -1, 1'b0, 1'b0, 2);
        do_read(6, 1, -1, 1'b0, 1'b0, -1);

        // Four beats without wlast end the burst; a stray fifth beat is dropped.
        for (int i = 0; i < 4; i++) begin
            dv[i] = $urandom; mv[i] = 4'hF;
        end
        do_write(7, 1, 4, 1'b0, 1'b0, 1'b1, dv, mv);
        do_read(7, 0, -1, 1'b0, 1'b0, -1);

        // Randomized mix with bus noise.
        for (int it = 0; it < 80; it++) begin
            line = $urandom_range(0, 16);
            if (line == 16) line = 1023;
            case ($urandom_range(0, 4))
                0, 1: begin
                    nb = $urandom_range(1, 4);
                    wl = (nb < 4) ? 1'b1 : 1'($urandom);
                    for (int i = 0; i < 4; i++) begin
                        dv[i] = $urandom; mv[i] = 4'($urandom_range(0, 15));
                    end
                    do_write(line, $urandom_range(0, 3), nb, wl, 1'b1, 1'($urandom), dv, mv);
                end
                2, 3: do_read(line, $urandom_range(0, 3), -1, 1'b1, 1'b1, -1);
                default: do_error(BASE_W + (27'($urandom) | 27'h1000), 1'($urandom),
                                  $urandom_range(1, 6));
            endcase
        end

        // Final sweep of every initialised line.
        for (int l = 0; l < 17; l++) begin
            do_read((l == 16) ? 1023 : l, l % 4, -1, 1'b0, 1'b0, -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
